// File: rtl/pc_fetch_unit.sv
// Program counter / fetch-address stage feeding the IDU: fetch, absolute load,
// two-cycle relative jump and HALT tracking. Define HALT_BUG_EN to model the HALT bug.
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Fetch,
  input  logic        i_Load,
  input  logic [15:0] i_LoadAddr,
  input  logic        i_JrStart,
  input  logic [7:0]  i_JrOffset,
  input  logic        i_Halt,
  input  logic        i_IntPending,
  input  logic        i_IME,
  input  logic [15:0] i_IduOut,
  output logic [15:0] o_IduIn,
  output logic        o_IduActive,
  output logic        o_IduDecrement,
  output logic [15:0] o_Addr,
  output logic        o_AddrValid,
  output logic [15:0] o_PC,
  output logic        o_Busy,
  output logic        o_Halted
);

  typedef enum logic [1:0] {RUN, JR_LO, JR_HI, HALTED} state_t;

  state_t             state;
  logic [15:0]        pc;
  logic [15:0]        addr_p1;
  logic               vld_p1;
  logic signed [7:0]  jr_off;
  logic               jr_carry;
  logic               bug_flag;
  logic               fetch_cmd;
  logic               idu_active;

  // Low-byte add of the displacement; returns {carry, sum}.
  function automatic logic [8:0] jr_lo_add(input logic [7:0] lo, input logic signed [7:0] off);
    jr_lo_add = {1'b0, lo} + {1'b0, off};
  endfunction

  // High-byte correction, wrapping mod 256.
  function automatic logic [7:0] jr_hi_adjust(input logic [7:0] hi, input logic carry,
                                              input logic signed [7:0] off);
    if (carry && (off >= 0))
      jr_hi_adjust = hi + 8'd1;
    else if (!carry && (off < 0))
      jr_hi_adjust = hi - 8'd1;
    else
      jr_hi_adjust = hi;
  endfunction

  assign fetch_cmd  = (state == RUN) & i_Fetch & ~i_Load & ~i_JrStart & ~i_Halt;
  // A pending HALT-bug fetch re-reads the same byte: the IDU stays idle.
  assign idu_active = fetch_cmd & ~bug_flag;

`ifndef HALT_BUG_EN
  assign bug_flag = 1'b0;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state   <= RUN;
      pc      <= RESET_PC;
      addr_p1 <= 16'h0000;
      vld_p1  <= 1'b0;
`ifdef HALT_BUG_EN
      bug_flag <= 1'b0;
`endif
    end else begin
      vld_p1 <= 1'b0;
      if (i_Load) begin
        pc    <= i_LoadAddr;
        state <= RUN;
`ifdef HALT_BUG_EN
        bug_flag <= 1'b0;
`endif
      end else begin
        case (state)
          RUN: begin
            if (i_JrStart) begin
              jr_off <= i_JrOffset;
              state  <= JR_LO;
            end else if (i_Halt) begin
              if (!i_IntPending)
                state <= HALTED;
`ifdef HALT_BUG_EN
              else if (!i_IME)
                bug_flag <= 1'b1;
`endif
            end else if (i_Fetch) begin
              addr_p1 <= pc;
              vld_p1  <= 1'b1;
              if (idu_active)
                pc <= i_IduOut;
`ifdef HALT_BUG_EN
              bug_flag <= 1'b0;
`endif
            end
          end
          JR_LO: begin
            {jr_carry, pc[7:0]} <= jr_lo_add(pc[7:0], jr_off);
            state               <= JR_HI;
          end
          JR_HI: begin
            pc[15:8] <= jr_hi_adjust(pc[15:8], jr_carry, jr_off);
            state    <= RUN;
`ifdef HALT_BUG_EN
            bug_flag <= 1'b0;
`endif
          end
          HALTED: begin
            if (i_IntPending)
              state <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  assign o_IduIn        = pc;
  assign o_IduActive    = idu_active;
  assign o_IduDecrement = 1'b0;
  assign o_Addr         = addr_p1;
  assign o_AddrValid    = vld_p1;
  assign o_PC           = pc;
  assign o_Busy         = (state == JR_LO) || (state == JR_HI);
  assign o_Halted       = (state == HALTED);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized run
// against a transaction-level reference model (honours HALT_BUG_EN like the design).
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, fetch, load, jr, halt, ip, ime;
  logic [15:0] load_addr;
  logic [7:0]  jr_off;
  logic [15:0] idu_out, idu_in, addr, pc;
  logic        idu_active, idu_dec, addr_vld, busy, halted;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: jump modelled as a whole 16-bit target with a cycle countdown.
  logic [15:0] m_pc, m_addr, m_tgt;
  logic        m_vld, m_halted, m_bug;
  int          m_busy;
  logic        exp_idu, seen_idu, chk_idu;

  always #5 clk = ~clk;

  // IDU stand-in: increments when enabled, returns garbage otherwise.
  assign idu_out = idu_active ? (idu_in + (idu_dec ? 16'hFFFF : 16'h0001)) : (idu_in ^ 16'hA5A5);

  pc_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Fetch(fetch), .i_Load(load), .i_LoadAddr(load_addr),
    .i_JrStart(jr), .i_JrOffset(jr_off), .i_Halt(halt), .i_IntPending(ip), .i_IME(ime),
    .i_IduOut(idu_out), .o_IduIn(idu_in), .o_IduActive(idu_active),
    .o_IduDecrement(idu_dec), .o_Addr(addr), .o_AddrValid(addr_vld), .o_PC(pc),
    .o_Busy(busy), .o_Halted(halted)
  );

  task automatic drive(input logic r, input logic ld, input logic [15:0] la, input logic j,
                       input logic [7:0] off, input logic h, input logic f,
                       input logic p, input logic e);
    @(negedge clk);
    rst = r; load = ld; load_addr = la; jr = j; jr_off = off;
    halt = h; fetch = f; ip = p; ime = e;
    chk_idu = !r;
    exp_idu = !r && !ld && (m_busy == 0) && !m_halted && !j && !h && f && !m_bug;
    #1 seen_idu = idu_active;
    @(posedge clk);
    m_vld = 1'b0;
    if (r) begin
      m_pc = 16'h0000; m_addr = 16'h0000; m_busy = 0; m_halted = 1'b0; m_bug = 1'b0;
    end else if (ld) begin
      m_pc = la; m_busy = 0; m_halted = 1'b0; m_bug = 1'b0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin m_pc = m_tgt; m_bug = 1'b0; end
    end else if (m_halted) begin
      if (p) m_halted = 1'b0;
    end else if (j) begin
      m_busy = 2;
      m_tgt  = m_pc + {{8{off[7]}}, off};
    end else if (h) begin
      if (!p) m_halted = 1'b1;
`ifdef HALT_BUG_EN
      else if (!e) m_bug = 1'b1;
`endif
    end else if (f) begin
      m_addr = m_pc; m_vld = 1'b1;
      if (m_bug) m_bug = 1'b0;
      else m_pc = m_pc + 16'h0001;
    end
    #1;
  endtask

  task automatic idle(input logic f);
    drive(0, 0, 16'h0, 0, 8'h0, 0, f, 0, 0);
  endtask

  task automatic test_reset;
    drive(1, 0, 16'h0, 0, 8'h0, 0, 0, 0, 0);
    drive(1, 0, 16'h0, 0, 8'h0, 0, 0, 0, 0);
    n_vec++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h want 0000", pc); end
    n_vec++; if (addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got %h want 0000", addr); end
    n_vec++; if ({addr_vld, busy, halted, idu_active, idu_dec} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl got %b want 00000", {addr_vld, busy, halted, idu_active, idu_dec});
    end
  endtask

  task automatic test_fetch;
    for (int k = 0; k < 3; k++) begin
      idle(1);
      n_vec++; if (addr !== 16'(k) || addr_vld !== 1'b1) begin
        n_fail++; $display("FAIL fetch_addr got %h/%b want %h/1", addr, addr_vld, 16'(k));
      end
      n_vec++; if (seen_idu !== 1'b1) begin n_fail++; $display("FAIL fetch_idu got %b want 1", seen_idu); end
    end
    n_vec++; if (pc !== 16'h0003) begin n_fail++; $display("FAIL fetch_pc got %h want 0003", pc); end
  endtask

  task automatic test_wrap;
    drive(0, 1, 16'hFFFF, 0, 8'h0, 0, 0, 0, 0);
    n_vec++; if (pc !== 16'hFFFF || addr_vld !== 1'b0) begin
      n_fail++; $display("FAIL wrap_load got %h/%b want ffff/0", pc, addr_vld);
    end
    idle(1);
    n_vec++; if (addr !== 16'hFFFF || pc !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_1 got addr %h pc %h want ffff 0000", addr, pc);
    end
    idle(1);
    n_vec++; if (addr !== 16'h0000 || pc !== 16'h0001) begin
      n_fail++; $display("FAIL wrap_2 got addr %h pc %h want 0000 0001", addr, pc);
    end
  endtask

  task automatic test_jr(input logic [15:0] start, input logic [7:0] off, input logic [15:0] want);
    drive(0, 1, start, 0, 8'h0, 0, 0, 0, 0);
    drive(0, 0, 16'h0, 1, off, 0, 0, 0, 0);
    n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL jr_busy1 got %b want 1", busy); end
    idle(1);
    n_vec++; if (busy !== 1'b1 || addr_vld !== 1'b0 || seen_idu !== 1'b0) begin
      n_fail++; $display("FAIL jr_busy2 got busy %b vld %b idu %b want 1 0 0", busy, addr_vld, seen_idu);
    end
    idle(1);
    n_vec++; if (busy !== 1'b0 || pc !== want) begin
      n_fail++; $display("FAIL jr_done got busy %b pc %h want 0 %h", busy, pc, want);
    end
  endtask

  task automatic test_load_priority;
    drive(0, 1, 16'h0038, 0, 8'h0, 0, 1, 0, 0);
    n_vec++; if (pc !== 16'h0038 || addr_vld !== 1'b0 || seen_idu !== 1'b0) begin
      n_fail++; $display("FAIL load_prio got pc %h vld %b idu %b want 0038 0 0", pc, addr_vld, seen_idu);
    end
  endtask

  task automatic test_halt;
    drive(0, 1, 16'h0100, 0, 8'h0, 0, 0, 0, 0);
    drive(0, 0, 16'h0, 0, 8'h0, 1, 0, 0, 0);
    n_vec++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_enter got %b want 1", halted); end
    idle(1);
    idle(1);
    n_vec++; if (pc !== 16'h0100 || addr_vld !== 1'b0 || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_hold got pc %h vld %b h %b want 0100 0 1", pc, addr_vld, halted);
    end
    drive(0, 0, 16'h0, 0, 8'h0, 0, 0, 1, 0);
    n_vec++; if (halted !== 1'b0 || pc !== 16'h0100) begin
      n_fail++; $display("FAIL halt_wake got h %b pc %h want 0 0100", halted, pc);
    end
  endtask

  task automatic test_halt_bug;
    logic [15:0] a2, p2;
`ifdef HALT_BUG_EN
    a2 = 16'h0201; p2 = 16'h0202;
`else
    a2 = 16'h0202; p2 = 16'h0203;
`endif
    drive(0, 1, 16'h0201, 0, 8'h0, 0, 0, 0, 0);
    drive(0, 0, 16'h0, 0, 8'h0, 1, 0, 1, 0);
    n_vec++; if (halted !== 1'b0) begin n_fail++; $display("FAIL hbug_nohalt got %b want 0", halted); end
    idle(1);
    n_vec++; if (addr !== 16'h0201) begin n_fail++; $display("FAIL hbug_f1 got %h want 0201", addr); end
    idle(1);
    n_vec++; if (addr !== a2 || pc !== p2) begin
      n_fail++; $display("FAIL hbug_f2 got addr %h pc %h want %h %h", addr, pc, a2, p2);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(199) == 0), ($urandom_range(11) == 0), 16'($urandom),
            ($urandom_range(9) == 0), 8'($urandom), ($urandom_range(9) == 0),
            ($urandom_range(1) == 0), ($urandom_range(3) == 0), ($urandom_range(1) == 0));
      if (chk_idu) begin
        n_vec++; if (seen_idu !== exp_idu) begin
          n_fail++; $display("FAIL rnd_idu cyc %0d got %b want %b", i, seen_idu, exp_idu);
        end
      end
      if (m_busy == 0) begin
        n_vec++; if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, pc, m_pc); end
      end
      n_vec++; if (addr !== m_addr || addr_vld !== m_vld) begin
        n_fail++; $display("FAIL rnd_addr cyc %0d got %h/%b want %h/%b", i, addr, addr_vld, m_addr, m_vld);
      end
      n_vec++; if (busy !== (m_busy > 0) || halted !== m_halted) begin
        n_fail++; $display("FAIL rnd_state cyc %0d got b%b h%b want b%b h%b", i, busy, halted, m_busy > 0, m_halted);
      end
    end
  endtask

  initial begin
    rst = 1'b1; fetch = 0; load = 0; load_addr = 0; jr = 0; jr_off = 0;
    halt = 0; ip = 0; ime = 0;
    m_pc = 0; m_addr = 0; m_tgt = 0; m_vld = 0; m_halted = 0; m_bug = 0; m_busy = 0;
    exp_idu = 0; seen_idu = 0; chk_idu = 0;
    test_reset();
    test_fetch();
    test_wrap();
    test_jr(16'h10F0, 8'h20, 16'h1110);
    test_jr(16'h1005, 8'hF0, 16'h0FF5);
    test_load_priority();
    test_halt();
    test_halt_bug();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
